// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: byte-to-HD44780 4-bit bus transmitter (RS/RW/E/D4-D7).
// One valid/ready handshake per command/data byte or single nibble; the block
// strobes E per nibble and holds off until the LCD execution time has elapsed.
// Optional macro LCD_POWERUP_INIT_EN: run the HD44780 4-bit power-up init
// sequence after reset before accepting requests.
module lcd_nibble_tx #(
    parameter int unsigned T_SETUP       = 4,
    parameter int unsigned T_EH          = 25,
    parameter int unsigned T_HOLD        = 2,
    parameter int unsigned T_GAP         = 100,
    parameter int unsigned T_CMD         = 4000,
    parameter int unsigned T_CLR         = 164000,
    parameter int unsigned INIT_WAIT_CYC = 1500000,
    parameter int unsigned INIT_N1_CYC   = 410000,
    parameter int unsigned INIT_N2_CYC   = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    input  logic       in_nib_only,
    output logic       init_done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [3:0] LCD_D
);

    function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = f_max(f_max(f_max(T_SETUP, T_EH), f_max(T_HOLD, T_GAP)),
                                          f_max(f_max(T_CMD, T_CLR),
                                                f_max(INIT_WAIT_CYC, f_max(INIT_N1_CYC, INIT_N2_CYC))));
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP,
        S_WAIT
    } state_t;

    // Execution wait (minus one, ready for the counter): clear/home needs the long one
    function automatic logic [CNT_W-1:0] f_wait_len(input logic rs, input logic [7:0] data);
        if (!rs && (data[7:2] == 6'd0) && (data != 8'd0)) begin
            return CNT_W'(T_CLR - 1);
        end
        return CNT_W'(T_CMD - 1);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;
    logic             r_rs;
    logic             w_rs_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_phase;
    logic             w_phase_nxt;
    logic [CNT_W-1:0] r_wait_len;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             w_load_user;
    logic             w_init_more;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic             r_init_done;
    logic             w_init_done_nxt;
    logic             r_lcd_rs;
    logic             w_lcd_rs_nxt;
    logic             r_lcd_rw;
    logic             r_lcd_e;
    logic             w_lcd_e_nxt;
    logic [3:0]       r_lcd_d;
    logic [3:0]       w_lcd_d_nxt;

`ifdef LCD_POWERUP_INIT_EN
    localparam int unsigned INIT_STEPS = 8;

    logic [3:0] r_init_step;
    logic [3:0] w_init_step_nxt;
    logic       w_load_init;

    // Init step table: {nibble_only, byte}
    function automatic logic [8:0] f_init_cmd(input logic [3:0] step);
        case (step)
            4'd0, 4'd1, 4'd2: return {1'b1, 8'h03};
            4'd3:             return {1'b1, 8'h02};
            4'd4:             return {1'b0, 8'h28};
            4'd5:             return {1'b0, 8'h0C};
            4'd6:             return {1'b0, 8'h06};
            default:          return {1'b0, 8'h01};
        endcase
    endfunction

    // Init step wait (minus one); the 0x3 nibbles have their own waits
    function automatic logic [CNT_W-1:0] f_init_wait(input logic [3:0] step);
        case (step)
            4'd0:    return CNT_W'(INIT_N1_CYC - 1);
            4'd1:    return CNT_W'(INIT_N2_CYC - 1);
            4'd7:    return CNT_W'(T_CLR - 1);
            default: return CNT_W'(T_CMD - 1);
        endcase
    endfunction

    assign w_init_more = (r_init_step != 4'(INIT_STEPS));
    assign w_load_init = w_init_more && w_cnt_zero && ((r_state == S_BOOT) || (r_state == S_WAIT));
`else
    assign w_init_more = 1'b0;
`endif

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_load_user = (r_state == S_IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every timed state exits when the shared counter hits zero
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  if (w_cnt_zero) w_state_nxt = w_init_more ? S_SETUP : S_IDLE;
            S_IDLE:  if (in_valid)   w_state_nxt = S_SETUP;
            S_SETUP: if (w_cnt_zero) w_state_nxt = S_PULSE;
            S_PULSE: if (w_cnt_zero) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_cnt_zero) w_state_nxt = r_phase ? S_WAIT : S_GAP;
            S_GAP:   if (w_cnt_zero) w_state_nxt = S_SETUP;
            S_WAIT:  if (w_cnt_zero) w_state_nxt = w_init_more ? S_SETUP : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values: request latch, counter reload, pin values
    always_comb begin
        w_cnt_nxt       = w_cnt_zero ? r_cnt : (r_cnt - CNT_W'(1));
        w_rs_nxt        = r_rs;
        w_data_nxt      = r_data;
        w_phase_nxt     = r_phase;
        w_wait_nxt      = r_wait_len;
        w_lcd_rs_nxt    = r_lcd_rs;
        w_lcd_d_nxt     = r_lcd_d;
        w_lcd_e_nxt     = (w_state_nxt == S_PULSE);
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_init_done_nxt = r_init_done | (w_state_nxt == S_IDLE);
`ifdef LCD_POWERUP_INIT_EN
        w_init_step_nxt = r_init_step;
`endif

        if (w_load_user) begin
            w_rs_nxt    = in_rs;
            w_data_nxt  = in_data;
            w_phase_nxt = in_nib_only;
            w_wait_nxt  = f_wait_len(in_rs, in_data);
        end
`ifdef LCD_POWERUP_INIT_EN
        else if (w_load_init) begin
            w_rs_nxt        = 1'b0;
            w_data_nxt      = f_init_cmd(r_init_step)[7:0];
            w_phase_nxt     = f_init_cmd(r_init_step)[8];
            w_wait_nxt      = f_init_wait(r_init_step);
            w_init_step_nxt = r_init_step + 4'd1;
        end
`endif

        if ((r_state == S_GAP) && w_cnt_zero) begin
            w_phase_nxt = 1'b1;
        end

        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_SETUP: w_cnt_nxt = CNT_W'(T_SETUP - 1);
                S_PULSE: w_cnt_nxt = CNT_W'(T_EH - 1);
                S_HOLD:  w_cnt_nxt = CNT_W'(T_HOLD - 1);
                S_GAP:   w_cnt_nxt = CNT_W'(T_GAP - 1);
                S_WAIT:  w_cnt_nxt = r_wait_len;
                default: w_cnt_nxt = '0;
            endcase
        end

        // RS/D only change on entry to SETUP
        if ((w_state_nxt == S_SETUP) && (r_state != S_SETUP)) begin
            w_lcd_rs_nxt = w_rs_nxt;
            w_lcd_d_nxt  = w_phase_nxt ? w_data_nxt[3:0] : w_data_nxt[7:4];
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef LCD_POWERUP_INIT_EN
            r_cnt       <= CNT_W'(INIT_WAIT_CYC - 1);
            r_init_step <= 4'd0;
`else
            r_cnt       <= '0;
`endif
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_phase     <= 1'b0;
            r_wait_len  <= '0;
            r_in_ready  <= 1'b0;
            r_init_done <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_rw    <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_lcd_d     <= 4'h0;
        end else begin
            r_cnt       <= w_cnt_nxt;
`ifdef LCD_POWERUP_INIT_EN
            r_init_step <= w_init_step_nxt;
`endif
            r_rs        <= w_rs_nxt;
            r_data      <= w_data_nxt;
            r_phase     <= w_phase_nxt;
            r_wait_len  <= w_wait_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_init_done <= w_init_done_nxt;
            r_lcd_rs    <= w_lcd_rs_nxt;
            r_lcd_rw    <= 1'b0;
            r_lcd_e     <= w_lcd_e_nxt;
            r_lcd_d     <= w_lcd_d_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign init_done = r_init_done;
    assign LCD_RS    = r_lcd_rs;
    assign LCD_RW    = r_lcd_rw;
    assign LCD_E     = r_lcd_e;
    assign LCD_D     = r_lcd_d;

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// tb_lcd_nibble_tx: directed bench for lcd_nibble_tx with shortened timing.
// Timing used: SETUP 4, EH 5, HOLD 2, GAP 10, CMD 40, CLR 160, init waits 30/20/15.
// Normal byte 72 cycles, clear/home byte 192, nibble-only 51, nibble-only home 171.
module tb_lcd_nibble_tx;

    localparam int unsigned P_SETUP = 4;
    localparam int unsigned P_EH    = 5;
    localparam int unsigned P_HOLD  = 2;
    localparam int unsigned P_GAP   = 10;
    localparam int unsigned P_CMD   = 40;
    localparam int unsigned P_CLR   = 160;
    localparam int unsigned P_IW    = 30;
    localparam int unsigned P_N1    = 20;
    localparam int unsigned P_N2    = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_nib_only;
    logic       init_done;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [3:0] LCD_D;

    int n_vec = 0;
    int n_err = 0;

    // pulse log written by the monitor only
    int         cyc = 0;
    int         p_n = 0;
    int         p_rise [64];
    int         p_w    [64];
    logic [3:0] p_d    [64];
    logic       p_rs   [64];
    logic       e_prev = 1'b0;
    logic       rw_bad = 1'b0;

    lcd_nibble_tx #(
        .T_SETUP(P_SETUP), .T_EH(P_EH), .T_HOLD(P_HOLD), .T_GAP(P_GAP),
        .T_CMD(P_CMD), .T_CLR(P_CLR),
        .INIT_WAIT_CYC(P_IW), .INIT_N1_CYC(P_N1), .INIT_N2_CYC(P_N2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_data(in_data), .in_nib_only(in_nib_only),
        .init_done(init_done),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_D(LCD_D)
    );

    always #5 clk = ~clk;

    // E-pulse monitor: sampled 2 ns after each rising edge
    always @(posedge clk) begin
        #2;
        cyc++;
        if (LCD_RW !== 1'b0) rw_bad = 1'b1;
        if ((LCD_E === 1'b1) && !e_prev && (p_n < 64)) begin
            p_rise[p_n] = cyc;
            p_d[p_n]    = LCD_D;
            p_rs[p_n]   = LCD_RS;
        end
        if ((LCD_E !== 1'b1) && e_prev) begin
            if (p_n < 64) p_w[p_n] = cyc - p_rise[p_n];
            p_n++;
        end
        e_prev = (LCD_E === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request from an idle negedge; returns at the negedge where in_ready is back
    task automatic send(input string tag, input logic rs, input logic [7:0] d,
                        input logic nib, input int exp_lat);
        int lat;
        int base;
        int acc;
        logic [3:0] n0;
        logic [3:0] n1;
        n0 = nib ? d[3:0] : d[7:4];
        n1 = d[3:0];
        chk({tag, " ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_rs = rs; in_data = d; in_nib_only = nib;
        @(negedge clk);
        in_valid = 1'b0; in_rs = ~rs; in_data = ~d; in_nib_only = ~nib;
        base = p_n;
        acc  = cyc;
        chk({tag, " ready_drop"}, 32'(in_ready), 32'd0);
        chk({tag, " setup_D"}, 32'(LCD_D), 32'(n0));
        chk({tag, " setup_RS"}, 32'(LCD_RS), 32'(rs));
        lat = 0;
        while ((in_ready !== 1'b1) && (lat < 400)) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " pulses"}, 32'(p_n - base), nib ? 32'd1 : 32'd2);
        chk({tag, " setup_time"}, 32'(p_rise[base] - acc), 32'(P_SETUP));
        chk({tag, " D0"}, 32'(p_d[base]), 32'(n0));
        chk({tag, " RS0"}, 32'(p_rs[base]), 32'(rs));
        chk({tag, " E_width0"}, 32'(p_w[base]), 32'(P_EH));
        if (!nib) begin
            chk({tag, " D1"}, 32'(p_d[base + 1]), 32'(n1));
            chk({tag, " RS1"}, 32'(p_rs[base + 1]), 32'(rs));
            chk({tag, " E_width1"}, 32'(p_w[base + 1]), 32'(P_EH));
            chk({tag, " rise_spacing"}, 32'(p_rise[base + 1] - p_rise[base]),
                32'(P_EH + P_HOLD + P_GAP + P_SETUP));
        end
        chk({tag, " D_held"}, 32'(LCD_D), nib ? 32'(n0) : 32'(n1));
        chk({tag, " RS_held"}, 32'(LCD_RS), 32'(rs));
        chk({tag, " E_idle"}, 32'(LCD_E), 32'd0);
    endtask

    initial begin
        int base;
        int lat;
        logic ready_done_split;
        logic [3:0] init_nib [12];

        rst_n = 1'b0; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00; in_nib_only = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst init_done", 32'(init_done), 32'd0);
        chk("rst LCD_RS", 32'(LCD_RS), 32'd0);
        chk("rst LCD_RW", 32'(LCD_RW), 32'd0);
        chk("rst LCD_E", 32'(LCD_E), 32'd0);
        chk("rst LCD_D", 32'(LCD_D), 32'd0);

`ifdef LCD_POWERUP_INIT_EN
        // requests held valid during init must be ignored
        init_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'hFF;
        base = p_n;
        rst_n = 1'b1;
        lat = 0;
        ready_done_split = 1'b0;
        while ((in_ready !== 1'b1) && (lat < 2000)) begin
            @(negedge clk);
            lat++;
            if (in_ready !== init_done) ready_done_split = 1'b1;
        end
        in_valid = 1'b0;
        chk("init latency", 32'(lat), 32'd597);
        chk("init ready_eq_done", 32'(ready_done_split), 32'd0);
        chk("init done", 32'(init_done), 32'd1);
        chk("init pulses", 32'(p_n - base), 32'd12);
        chk("init first_rise", 32'(p_rise[base]), 32'(P_IW + P_SETUP + 3));
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("init nib%0d", i), 32'(p_d[base + i]), 32'(init_nib[i]));
            chk($sformatf("init rs%0d", i), 32'(p_rs[base + i]), 32'd0);
        end
        @(negedge clk);
`else
        init_nib = '{default: 4'h0};
        ready_done_split = 1'b0;
        lat = 0;
        rst_n = 1'b1;
        #1;
        chk("release ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("release in_ready", 32'(in_ready), 32'd1);
        chk("release init_done", 32'(init_done), 32'd1);
`endif

        send("data41", 1'b1, 8'h41, 1'b0, 72);
        send("clear01", 1'b0, 8'h01, 1'b0, 192);
        send("cmd80", 1'b0, 8'h80, 1'b0, 72);
        send("nib33", 1'b0, 8'h33, 1'b1, 51);
        send("nibhome02", 1'b0, 8'h02, 1'b1, 171);
        send("cmd04", 1'b0, 8'h04, 1'b0, 72);
        send("data01", 1'b1, 8'h01, 1'b0, 72);

        // valid held with changing data: accepts at edges 0 and 73 only
        base = p_n;
        in_valid = 1'b1; in_rs = 1'b1; in_nib_only = 1'b0;
        for (int j = 0; j < 146; j++) begin
            in_data = 8'(8'h10 + j);
            @(negedge clk);
        end
        chk("b2b ready_after_two", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("b2b pulses", 32'(p_n - base), 32'd4);
        chk("b2b nib0", 32'(p_d[base]), 32'h1);
        chk("b2b nib1", 32'(p_d[base + 1]), 32'h0);
        chk("b2b nib2", 32'(p_d[base + 2]), 32'h5);
        chk("b2b nib3", 32'(p_d[base + 3]), 32'h9);
        chk("b2b zero_gap", 32'(p_rise[base + 2] - p_rise[base]), 32'd73);
        chk("b2b in_ready", 32'(in_ready), 32'd1);

`ifndef LCD_POWERUP_INIT_EN
        // reset during the first E pulse
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'hA5; in_nib_only = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid E_before", 32'(LCD_E), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid E", 32'(LCD_E), 32'd0);
        chk("rstmid D", 32'(LCD_D), 32'd0);
        chk("rstmid RS", 32'(LCD_RS), 32'd0);
        chk("rstmid in_ready", 32'(in_ready), 32'd0);
        chk("rstmid init_done", 32'(init_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = p_n;
        chk("rstmid ready_after", 32'(in_ready), 32'd1);
        repeat (100) @(negedge clk);
        chk("rstmid no_pulses", 32'(p_n - base), 32'd0);
        chk("rstmid E_quiet", 32'(LCD_E), 32'd0);
`endif

        chk("RW always 0", 32'(rw_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
